req_fifo: RTL and testbench

REQ_FIFO -- requirements
Module: req_fifo

---
 rtl/req_fifo.sv | 137 +++++++++++++
 tb/tb_req_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/req_fifo.sv
// req_fifo: single-clock request FIFO between the VPI producer and the
// mem_controller consumer. Registered read data, registered status flags
// and sticky error flags.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   wr_en      in   write request
//   data_in    in   write word (TID, flag, address, data)
//   full       out  occupancy == DEPTH
//   rd_en      in   read request
//   data_out   out  registered read word, valid the cycle after an accepted read
//   empty      out  occupancy == 0
//   count      out  occupancy, 0..DEPTH
//   overflow   out  sticky, set by a rejected write
//   underflow  out  sticky, set by a rejected read
module req_fifo #(
  parameter int unsigned DATA_WIDTH      = 80,
  parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  output logic                       full,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       empty,
  output logic [FIFO_ADDR_WIDTH:0]   count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned DEPTH = 2 ** FIFO_ADDR_WIDTH;
  localparam int unsigned CNT_W = FIFO_ADDR_WIDTH + 1;
  localparam int unsigned PTR_W = FIFO_ADDR_WIDTH;

  // Storage array; never reset, stale contents are unreachable after reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  rd_acc;
  logic                  wr_acc;

  // Accept decode: a read frees a slot, so a write into a full FIFO is
  // accepted whenever a read is accepted on the same edge.
  always_comb begin
    rd_acc = rd_en && !empty_q;
    wr_acc = wr_en && (!full_q || rd_acc);
  end

  // Next-state logic for pointers, occupancy, status and read data.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    // Pointers are exactly PTR_W bits, so DEPTH-1 wraps to 0 naturally.
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      data_out_d = mem_q[rd_ptr_q];
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (wr_en && !wr_acc) begin
      overflow_d = 1'b1;
    end
    if (rd_en && !rd_acc) begin
      underflow_d = 1'b1;
    end

    // Flags are registered copies of the count decode, so they change on the
    // same edge as count and never see wr_en/rd_en combinationally.
    empty_d = (count_d == CNT_W'(0));
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Memory write port. Reading mem_q[rd_ptr_q] on the same edge returns the
  // old contents, so a full-FIFO read+write hands out the oldest word while the
  // new word lands in the slot just freed.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign data_out  = data_out_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_req_fifo.sv
// tb_req_fifo: directed bench for req_fifo with a queue-based reference model
// checked every cycle, plus literal expectations at key points.
module tb_req_fifo;

  localparam int unsigned DW    = 80;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          full;
  logic          rd_en;
  logic [DW-1:0] data_out;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int tests;
  int fails;

  req_fifo #(.DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .data_in   (data_in),
    .full      (full),
    .rd_en     (rd_en),
    .data_out  (data_out),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue plus the last word handed out.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  logic          m_ovf;
  logic          m_unf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      automatic int  sz    = mq.size();
      automatic bit  rd_ok = rd_en && (sz != 0);
      automatic bit  wr_ok = wr_en && ((sz < DEPTH) || rd_ok);
      if (rd_ok) m_dout = mq.pop_front();
      if (wr_ok) mq.push_back(data_in);
      if (wr_en && !wr_ok) m_ovf = 1'b1;
      if (rd_en && !rd_ok) m_unf = 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("count", DW'(count), DW'(mq.size()));
      check("empty", DW'(empty), DW'(mq.size() == 0));
      check("full", DW'(full), DW'(mq.size() == DEPTH));
      check("data_out", data_out, m_dout);
      check("overflow", DW'(overflow), DW'(m_ovf));
      check("underflow", DW'(underflow), DW'(m_unf));
      check("count_bound", DW'(count <= 5'(DEPTH)), DW'(1));
    end
  end

  // One clock with the given inputs; returns just after the falling edge.
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    @(posedge clk);
    @(negedge clk);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    @(negedge clk);
    // Requests during reset must be ignored.
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    data_in = 80'h99;
    @(negedge clk);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    reset   = 1'b0;

    // Reset state.
    check("rst_count", DW'(count), 80'd0);
    check("rst_empty", DW'(empty), 80'd1);
    check("rst_full", DW'(full), 80'd0);
    check("rst_dout", data_out, 80'd0);
    check("rst_ovf", DW'(overflow), 80'd0);
    check("rst_unf", DW'(underflow), 80'd0);

    // Basic write three, read three.
    for (int i = 1; i <= 3; i++) cyc(1'b1, DW'(i), 1'b0);
    check("basic_count3", DW'(count), 80'd3);
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0, '0, 1'b1);
      check("basic_dout", data_out, DW'(i));
    end
    check("basic_empty", DW'(empty), 80'd1);
    check("basic_count0", DW'(count), 80'd0);

    // Fill, overflow, drain.
    for (int i = 0; i < 16; i++) cyc(1'b1, DW'(8'h10 + i), 1'b0);
    check("fill_full", DW'(full), 80'd1);
    check("fill_count", DW'(count), 80'd16);
    cyc(1'b1, 80'hAA, 1'b0);
    check("ovf_set", DW'(overflow), 80'd1);
    check("ovf_count", DW'(count), 80'd16);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, '0, 1'b1);
      check("drain_dout", data_out, DW'(8'h10 + i));
    end
    check("drain_empty", DW'(empty), 80'd1);

    // Full with simultaneous read and write.
    for (int i = 0; i < 16; i++) cyc(1'b1, DW'(8'h20 + i), 1'b0);
    cyc(1'b1, 80'h55, 1'b1);
    check("fullrw_dout", data_out, 80'h20);
    check("fullrw_count", DW'(count), 80'd16);
    for (int i = 1; i < 16; i++) begin
      cyc(1'b0, '0, 1'b1);
      check("fullrw_drain", data_out, DW'(8'h20 + i));
    end
    cyc(1'b0, '0, 1'b1);
    check("fullrw_last", data_out, 80'h55);

    // Empty with simultaneous read and write; flags cleared by reset first.
    do_reset();
    check("rst2_ovf", DW'(overflow), 80'd0);
    cyc(1'b1, 80'h77, 1'b1);
    check("emptyrw_unf", DW'(underflow), 80'd1);
    check("emptyrw_count", DW'(count), 80'd1);
    check("emptyrw_dout", data_out, 80'd0);
    cyc(1'b0, '0, 1'b1);
    check("emptyrw_read", data_out, 80'h77);
    cyc(1'b0, '0, 1'b1);
    check("empty_rd_hold", data_out, 80'h77);
    check("empty_rd_unf", DW'(underflow), 80'd1);

    // Pointer wrap with random interleave, four rounds of ten.
    for (int round = 0; round < 4; round++) begin
      int wn, rn, budget;
      wn = 0;
      rn = 0;
      budget = 0;
      while ((wn < 10 || rn < 10) && budget < 200) begin
        logic w, r;
        w = (wn < 10) && ($urandom_range(0, 1) == 1);
        r = (rn < wn) && ($urandom_range(0, 1) == 1);
        cyc(w, {16'(round), 32'(wn), 32'hC0DE_0000 + 32'(wn)}, r);
        if (w) wn++;
        if (r) rn++;
        budget++;
      end
      check("wrap_done", DW'(budget < 200), 80'd1);
      check("wrap_empty", DW'(empty), 80'd1);
    end

    // Asynchronous reset between edges.
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(8'hE0 + i), 1'b0);
    cyc(1'b0, '0, 1'b1);
    check("pre_arst_dout", data_out, 80'hE0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_count", DW'(count), 80'd0);
    check("arst_empty", DW'(empty), 80'd1);
    check("arst_dout", data_out, 80'd0);
    check("arst_unf", DW'(underflow), 80'd0);
    @(negedge clk);
    reset = 1'b0;
    check("post_arst_empty", DW'(empty), 80'd1);
    cyc(1'b1, 80'hBEEF, 1'b0);
    cyc(1'b0, '0, 1'b1);
    check("post_arst_dout", data_out, 80'hBEEF);
    check("post_arst_empty2", DW'(empty), 80'd1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
